// File: rtl/btn_conditioner_if.sv
// Conditioned push-button bundle: raw level in, debounced events and level out.
// press/release_pulse/long_press are single-cycle strobes; pressed is a steady level.
interface btn_conditioner_if;
    logic btn_raw;
    logic press;
    logic release_pulse;
    logic long_press;
    logic pressed;

    modport master (
        input  btn_raw,
        output press,
        output release_pulse,
        output long_press,
        output pressed
    );

    modport slave (
        output btn_raw,
        input  press,
        input  release_pulse,
        input  long_press,
        input  pressed
    );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, debounce FSM, long-press timer.
// All outputs are registered; state is exposed for debug.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 20
) (
    input  logic              clock,
    input  logic              reset,
    btn_conditioner_if.master btn,
    output logic [1:0]        state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic          s1;
    logic          btn_sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_d;
    logic          press_d;
    logic          release_d;
    logic          long_d;
    logic          pressed_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1       <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            s1       <= btn.btn_raw;
            btn_sync <= s1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur               <= RELEASED;
            cnt               <= '0;
            hcnt              <= '0;
            btn.press         <= 1'b0;
            btn.release_pulse <= 1'b0;
            btn.long_press    <= 1'b0;
            btn.pressed       <= 1'b0;
        end else begin
            cur               <= nxt;
            cnt               <= cnt_d;
            hcnt              <= hcnt_d;
            btn.press         <= press_d;
            btn.release_pulse <= release_d;
            btn.long_press    <= long_d;
            btn.pressed       <= pressed_d;
        end
    end

    always_comb begin
        nxt    = cur;
        cnt_d  = cnt;
        hcnt_d = hcnt;
        case (cur)
            RELEASED: begin
                if (btn_sync) begin
                    nxt   = PRESS_DB;
                    cnt_d = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (!btn_sync) begin
                    nxt = RELEASED;
                end else if (cnt == CNT_DONE) begin
                    nxt    = HELD;
                    hcnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    nxt   = RELEASE_DB;
                    cnt_d = CNT_ONE;
                end
            end
            RELEASE_DB: begin
                // A bounce back to 1 resumes HELD without clearing the hold timer.
                if (btn_sync) begin
                    nxt = HELD;
                end else if (cnt == CNT_DONE) begin
                    nxt = RELEASED;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: nxt = RELEASED;
        endcase
        if ((cur == HELD || cur == RELEASE_DB) && hcnt != HOLD_MAX) begin
            hcnt_d = hcnt + HW'(1);
        end
    end

    always_comb begin
        press_d   = (cur == PRESS_DB) && btn_sync && (cnt == CNT_DONE);
        release_d = (cur == RELEASE_DB) && !btn_sync && (cnt == CNT_DONE);
        // An accepted release on the same edge suppresses the long press.
        long_d    = (cur == HELD || cur == RELEASE_DB) && (hcnt == HOLD_LAST) && !release_d;
        pressed_d = (nxt == HELD) || (nxt == RELEASE_DB);
        state     = cur;
    end
endmodule
